// File: rtl/mcpu_pkg.sv
// Shared MicroCPU definitions: default word/address widths, reset PC and the
// prefetch queue entry layout.
package mcpu_pkg;

    localparam int MCPU_WORD_SIZE  = 8;
    localparam int MCPU_ADDR_WIDTH = 8;
    localparam int MCPU_RESET_PC   = 0;

    typedef struct packed {
        logic [MCPU_ADDR_WIDTH-1:0] pc;
        logic [MCPU_WORD_SIZE-1:0]  instr;
    } fetch_entry_t;

endpackage

// File: rtl/mcpu_fetch_queue.sv
// Circular prefetch buffer of DEPTH entries with push/pop/flush; the head
// entry is always visible on dout.
module mcpu_fetch_queue
    import mcpu_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t,
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        din,
    output entry_t        dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        mem_q [DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Pointer and occupancy next-state; flush wins over push/pop
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = ptr_inc(tail_q);
            end else begin
                tail_d = tail_q;
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end else begin
                head_d = head_q;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is cleared on reset so the head never reads as X
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !flush) begin
            mem_q[tail_q] <= din;
        end
    end

    assign dout  = mem_q[head_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/mcpu_fetch_unit.sv
// MicroCPU fetch stage: owns the PC, reads the RAM instruction port and feeds
// decode through a small prefetch queue; branch redirect flushes the queue.
module mcpu_fetch_unit #(
    parameter int                  WORD_SIZE  = mcpu_pkg::MCPU_WORD_SIZE,
    parameter int                  ADDR_WIDTH = mcpu_pkg::MCPU_ADDR_WIDTH,
    parameter int                  DEPTH      = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(mcpu_pkg::MCPU_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_en,
    output logic [ADDR_WIDTH-1:0] instraddr,
    input  logic [WORD_SIZE-1:0]  instrrd,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [WORD_SIZE-1:0]  instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc
);

    import mcpu_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [WORD_SIZE-1:0]  instr;
    } entry_t;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  pop_s;
    logic                  fetch_s;
    logic [CW-1:0]         q_count_s;
    logic                  q_full_s;
    logic                  q_empty_s;
    entry_t                q_din_s;
    entry_t                q_dout_s;

    assign pop_s   = (q_count_s != '0) & instr_ready;
    // A pop in the same cycle frees the slot the new fetch lands in
    assign fetch_s = fetch_en & ~redirect_valid & (~q_full_s | pop_s);
    assign q_din_s = '{pc: pc_q, instr: instrrd};

    // PC next-state: redirect beats sequential fetch; wraps naturally
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_addr;
        end else if (fetch_s) begin
            pc_d = pc_q + ADDR_WIDTH'(1);
        end else begin
            pc_d = pc_q;
        end
    end

    // Program counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    mcpu_fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk   (clk),
        .rst   (reset),
        .push  (fetch_s),
        .pop   (pop_s & ~redirect_valid),
        .flush (redirect_valid),
        .din   (q_din_s),
        .dout  (q_dout_s),
        .count (q_count_s),
        .full  (q_full_s),
        .empty (q_empty_s)
    );

    assign instraddr   = pc_q;
    assign instr_valid = ~q_empty_s;
    assign instr_data  = q_dout_s.instr;
    assign instr_pc    = q_dout_s.pc;

endmodule

// File: tb/tb_mcpu_fetch_unit.sv
// Directed bench for mcpu_fetch_unit with a combinational RAM model holding
// the repeating pattern 04,08,01,09.
module tb_mcpu_fetch_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fetch_en = 1'b0;
    logic       redirect_valid = 1'b0;
    logic [7:0] redirect_addr = 8'h00;
    logic       instr_ready = 1'b0;
    logic [7:0] instraddr;
    logic [7:0] instrrd;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic [7:0] instr_pc;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_word(input logic [7:0] a);
        case (a[1:0])
            2'd0:    return 8'h04;
            2'd1:    return 8'h08;
            2'd2:    return 8'h01;
            default: return 8'h09;
        endcase
    endfunction

    assign instrrd = mem_word(instraddr);

    mcpu_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .instraddr      (instraddr),
        .instrrd        (instrrd),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    typedef struct {
        logic       fen;
        logic       rdy;
        logic       rv;
        logic [7:0] ra;
        logic       ev;
        logic       chk_head;
        logic [7:0] epc;
        logic [7:0] edata;
        logic [7:0] eaddr;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [7:0] epc,
                           input logic [7:0] edata, input logic [7:0] eaddr);
        chk({tag, " valid"}, {7'b0, instr_valid}, {7'b0, ev});
        chk({tag, " addr"}, instraddr, eaddr);
        if (ev) begin
            chk({tag, " pc"}, instr_pc, epc);
            chk({tag, " data"}, instr_data, edata);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst valid", {7'b0, instr_valid}, 8'h00);
        chk("rst addr", instraddr, 8'h00);
        chk("rst data", instr_data, 8'h00);
        chk("rst pc", instr_pc, 8'h00);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // fen rdy rv ra | ev chk pc data addr
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 8'h04, 8'h01};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 8'h08, 8'h02};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 8'h01, 8'h03};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 8'h09, 8'h04};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 8'h09, 8'h05};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 8'h09, 8'h05};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 8'h10};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 8'h04, 8'h11};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFE};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFE, 8'h01, 8'hFF};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 8'h09, 8'h00};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 8'h04, 8'h01};

        // Streaming, fill/stall, redirect while full, redirect across the wrap
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        do_reset();
        chk("post-rst addr", instraddr, 8'h00);
        for (int i = 0; i < 12; i++) begin
            fetch_en       = tbl[i].fen;
            instr_ready    = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_addr  = tbl[i].ra;
            step();
            chk($sformatf("vec%0d valid", i), {7'b0, instr_valid}, {7'b0, tbl[i].ev});
            chk($sformatf("vec%0d addr", i), instraddr, tbl[i].eaddr);
            if (tbl[i].chk_head) begin
                chk($sformatf("vec%0d pc", i), instr_pc, tbl[i].epc);
                chk($sformatf("vec%0d data", i), instr_data, tbl[i].edata);
            end
        end
        redirect_valid = 1'b0;

        // Decode stalled from reset: fill, hold, then drain without loss
        fetch_en    = 1'b1;
        instr_ready = 1'b0;
        do_reset();
        step(); chk_out("stall e1", 1'b1, 8'h00, 8'h04, 8'h01);
        step(); chk_out("stall e2", 1'b1, 8'h00, 8'h04, 8'h02);
        step(); chk_out("stall e3", 1'b1, 8'h00, 8'h04, 8'h02);
        instr_ready = 1'b1;
        step(); chk_out("drain e4", 1'b1, 8'h01, 8'h08, 8'h03);
        step(); chk_out("drain e5", 1'b1, 8'h02, 8'h01, 8'h04);

        // Asynchronous reset between edges while streaming
        reset = 1'b1;
        #1;
        chk_out("async rst", 1'b0, 8'h00, 8'h00, 8'h00);
        chk("async rst data", instr_data, 8'h00);
        chk("async rst pc", instr_pc, 8'h00);
        #2;
        reset = 1'b0;
        step(); chk_out("restart e1", 1'b1, 8'h00, 8'h04, 8'h01);
        step(); chk_out("restart e2", 1'b1, 8'h01, 8'h08, 8'h02);

        // fetch_en low drains the queue; redirect on the last pop
        fetch_en    = 1'b1;
        instr_ready = 1'b0;
        do_reset();
        step();
        step(); chk_out("fen0 full", 1'b1, 8'h00, 8'h04, 8'h02);
        fetch_en    = 1'b0;
        instr_ready = 1'b1;
        step(); chk_out("fen0 pop1", 1'b1, 8'h01, 8'h08, 8'h02);
        redirect_valid = 1'b1;
        redirect_addr  = 8'h20;
        step(); chk_out("fen0 redir", 1'b0, 8'h00, 8'h00, 8'h20);
        redirect_valid = 1'b0;
        step(); chk_out("fen0 frozen", 1'b0, 8'h00, 8'h00, 8'h20);
        fetch_en = 1'b1;
        step(); chk_out("fen1 resume", 1'b1, 8'h20, 8'h04, 8'h21);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
